pipelined_arith_unit: RTL and testbench

PIPELINED_ARITH_UNIT -- requirements
Module: pipelined_arith_unit

---
 rtl/arith_pkg.sv | 30 +++
 rtl/seq_mul.sv | 52 +++++
 rtl/pipelined_arith_unit.sv | 139 +++++++++++++
 tb/tb_pipelined_arith_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared types and constants for the pipelined arithmetic unit.
// Op encodings, FSM state type and saturation-limit helpers.
package arith_pkg;

  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_CMP     = 3'b010,
    OP_ABSDIFF = 3'b011,
    OP_MUL     = 3'b100,
    OP_MIN     = 3'b101,
    OP_MAX     = 3'b110,
    OP_RSV     = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/seq_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Bit 0 is folded into the start edge so done_o fires WIDTH-1 edges later.
module seq_mul
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] term;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  assign term   = mplier_q[0] ? mcand_q : '0;
  assign prod_o = acc_q + term;
  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, mcand_i} << 1;
      mplier_q <= mplier_i >> 1;
      acc_q    <= mplier_i[0] ? {{WIDTH{1'b0}}, mcand_i} : '0;
      cnt_q    <= CW'(1);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= prod_o;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pipelined_arith_unit.sv
// Signed ALU with wrap/saturate, flags, sticky overflow and an
// iterative multiplier, sequenced by an IDLE/MUL/DONE handshake FSM.
module pipelined_arith_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic [2:0]              op,
  input  logic                    sat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    zero,
  output logic                    negative,
  output logic                    ovf_sticky,
  input  logic                    clr_sticky
);

  localparam int EW = WIDTH + 2;
  localparam int PW = 2 * WIDTH;
  localparam logic signed [EW-1:0] EMAX = EW'(sat_max(WIDTH));
  localparam logic signed [EW-1:0] EMIN = EW'(sat_min(WIDTH));
  localparam logic signed [EW-1:0] EONE = 1;
  localparam logic signed [PW-1:0] PMAX = PW'(sat_max(WIDTH));
  localparam logic signed [PW-1:0] PMIN = PW'(sat_min(WIDTH));

  state_e state_q;
  logic   sign_q;
  logic   sat_q;

  logic signed [EW-1:0]    ea, eb, ex, esel;
  logic                    arith;
  logic                    alu_ovf;
  logic signed [WIDTH-1:0] alu_res;

  // Exact result in WIDTH+2 bits so range checks never wrap.
  always_comb begin
    ea    = EW'(a);
    eb    = EW'(b);
    ex    = '0;
    arith = 1'b0;
    unique case (op_e'(op))
      OP_ADD:     begin ex = ea + eb; arith = 1'b1; end
      OP_SUB:     begin ex = ea - eb; arith = 1'b1; end
      OP_ABSDIFF: begin
        ex    = (ea > eb) ? ea - eb : eb - ea;
        arith = 1'b1;
      end
      OP_CMP:     ex = (ea > eb) ? EONE : (ea == eb) ? '0 : -EONE;
      OP_MIN:     ex = (ea < eb) ? ea : eb;
      OP_MAX:     ex = (ea > eb) ? ea : eb;
      default:    ex = '0;
    endcase
    alu_ovf = arith && (ex > EMAX || ex < EMIN);
    esel    = (alu_ovf && sat) ? (ex[EW-1] ? EMIN : EMAX) : ex;
    alu_res = esel[WIDTH-1:0];
  end

  logic [WIDTH-1:0]        mag_a, mag_b;
  logic                    start, mul_done;
  logic [PW-1:0]           prod;
  logic signed [PW-1:0]    pex, psel;
  logic                    mul_ovf;
  logic signed [WIDTH-1:0] mul_res;

  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;
  assign start = (state_q == S_IDLE) && in_valid && (op_e'(op) == OP_MUL);

  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .mcand_i  (mag_a),
    .mplier_i (mag_b),
    .done_o   (mul_done),
    .prod_o   (prod)
  );

  assign pex     = sign_q ? -$signed(prod) : $signed(prod);
  assign mul_ovf = (pex > PMAX) || (pex < PMIN);
  assign psel    = (mul_ovf && sat_q) ? (pex[PW-1] ? PMIN : PMAX) : pex;
  assign mul_res = psel[WIDTH-1:0];

  logic                    fin, fin_ovf;
  logic signed [WIDTH-1:0] fin_res;

  assign fin = ((state_q == S_IDLE) && in_valid && !start)
            || ((state_q == S_MUL) && mul_done);
  assign fin_res  = (state_q == S_MUL) ? mul_res : alu_res;
  assign fin_ovf  = (state_q == S_MUL) ? mul_ovf : alu_ovf;
  assign in_ready = (state_q == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sign_q     <= 1'b0;
      sat_q      <= 1'b0;
      out_valid  <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
      negative   <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (clr_sticky) ovf_sticky <= 1'b0;
      // A delivered overflow beats a simultaneous clear.
      if (fin) begin
        out_valid <= 1'b1;
        result    <= fin_res;
        overflow  <= fin_ovf;
        zero      <= (fin_res == '0);
        negative  <= fin_res[WIDTH-1];
        if (fin_ovf) ovf_sticky <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: if (in_valid) begin
          sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
          sat_q   <= sat;
          state_q <= start ? S_MUL : S_DONE;
        end
        S_MUL:  if (mul_done) state_q <= S_DONE;
        S_DONE: if (out_ready) begin
          state_q   <= S_IDLE;
          out_valid <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipelined_arith_unit.sv
// Directed plus random checks of pipelined_arith_unit against
// an integer-arithmetic reference model.
module tb_pipelined_arith_unit;

  localparam int W = 8;
  localparam longint MX = (64'sd1 <<< (W - 1)) - 1;
  localparam longint MN = -(64'sd1 <<< (W - 1));

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] a, b;
  logic [2:0]          op;
  logic                sat;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] result;
  logic                overflow, zero, negative, ovf_sticky;
  logic                clr_sticky;

  int total = 0;
  int bad   = 0;
  bit exp_sticky = 1'b0;

  pipelined_arith_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .sat        (sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .overflow   (overflow),
    .zero       (zero),
    .negative   (negative),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int opc, input int x, input int y,
                                input bit s, output longint r,
                                output bit ov);
    longint e;
    case (opc)
      0: e = x + y;
      1: e = x - y;
      2: e = (x > y) ? 1 : (x == y) ? 0 : -1;
      3: e = (x > y) ? x - y : y - x;
      4: e = longint'(x) * y;
      5: e = (x < y) ? x : y;
      6: e = (x > y) ? x : y;
      default: e = 0;
    endcase
    ov = (opc inside {0, 1, 3, 4}) && (e > MX || e < MN);
    if (ov && s) r = (e < 0) ? MN : MX;
    else begin
      r = e & ((64'sd1 <<< W) - 1);
      if (r > MX) r = r - (64'sd1 <<< W);
    end
  endfunction

  task automatic run(input int opc, input int x, input int y, input bit s,
                     input int hold, input bit clr);
    longint er;
    bit     eo;
    int     n;
    int     lat;
    model(opc, x, y, s, er, eo);
    lat = (opc == 4) ? W : 1;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; op = 3'(opc); a = W'(x); b = W'(y);
    sat = s; clr_sticky = clr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    clr_sticky = 1'b0;
    if (eo) exp_sticky = 1'b1;
    else if (clr) exp_sticky = 1'b0;
    chk("latency", n, lat);
    chk("result", result, er);
    chk("overflow", overflow, eo);
    chk("zero", zero, er == 0);
    chk("negative", negative, er < 0);
    chk("sticky", ovf_sticky, exp_sticky);
    chk("in_ready_done", in_ready, 0);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_result", result, er);
      chk("hold_ovf", overflow, eo);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
    sat = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_zero", zero, 0);
    chk("rst_neg", negative, 0);
    chk("rst_sticky", ovf_sticky, 0);
    rst = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);

    run(0, 50, 70, 0, 0, 0);
    run(0, 100, 50, 0, 0, 0);
    run(0, 100, 50, 1, 0, 0);
    run(3, -100, 100, 1, 0, 0);
    run(2, 10, 30, 0, 0, 0);
    run(4, -12, 10, 0, 0, 0);
    run(4, 16, 16, 0, 0, 0);
    run(4, 16, 16, 1, 0, 0);
    run(4, -128, -128, 1, 0, 0);
    run(1, -128, 1, 1, 0, 0);
    run(7, 5, 9, 1, 0, 0);
    run(0, 127, 0, 0, 3, 0);

    // request waiting during DONE is taken only after the handshake
    run(0, 1, 1, 0, 0, 1);
    in_valid = 1'b1; op = 3'b000; a = 8'sd5; b = 8'sd6; sat = 1'b0;
    @(posedge clk); #1;
    a = 8'sd1; b = 8'sd2;
    chk("bp_first", result, 11);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_stable", result, 11);
      chk("bp_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_no_accept", out_valid, 0);
    chk("bp_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_res", result, 3);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    run(0, 100, 100, 0, 0, 0);
    run(0, 100, 100, 0, 0, 1);

    // reset mid-multiply
    in_valid = 1'b1; op = 3'b100; a = 8'sd5; b = 8'sd7; sat = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_sticky", ovf_sticky, 0);
    chk("mrst_result", result, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_sticky = 1'b0;
    chk("mrst_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("mrst_no_ghost", out_valid, 0);
    run(0, 20, 22, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      run(int'($urandom_range(7)),
          int'($urandom_range(255)) - 128,
          int'($urandom_range(255)) - 128,
          1'($urandom_range(1)),
          int'($urandom_range(2)),
          1'($urandom_range(3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
